// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
// Bundles the serial-input / control / status signals of seq_detector_param.
//   master : drives x, en, overlap, load, pattern_in, clear; observes y, count,
//            pattern (stream source / controller side)
//   slave  : the detector itself
// Parameters must match the detector instance (PAT_W, CNT_W).
// -----------------------------------------------------------------------------
interface seq_detector_param_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             x;           // serial data bit
   logic             en;          // x valid this edge
   logic             overlap;     // 1 = overlapping matches
   logic             load;        // latch pattern_in
   logic [PAT_W-1:0] pattern_in;  // bit PAT_W-1 is the oldest bit
   logic             clear;       // clear counter and history
   logic             y;           // registered match flag
   logic [CNT_W-1:0] count;       // saturating match count
   logic [PAT_W-1:0] pattern;     // current pattern register

   modport master (
      output x, en, overlap, load, pattern_in, clear,
      input  y, count, pattern
   );

   modport slave (
      input  x, en, overlap, load, pattern_in, clear,
      output y, count, pattern
   );
endinterface

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial pattern detector: compares the most recent PAT_W accepted bits against
// a run-time loadable pattern, with selectable overlapping / non-overlapping
// matching and a saturating match counter.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : seq_detector_param_if.slave (x, en, overlap, load, pattern_in, clear
//          in; y, count, pattern out)
// -----------------------------------------------------------------------------
module seq_detector_param #(
   parameter int               PAT_W   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [PAT_W-1:0] RST_PAT = 4'b1011
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_detector_param_if.slave  bus
);

   localparam int             FW   = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]  FULL = FW'(PAT_W);

   // FILLING until PAT_W valid bits are held; the state is derived from fill.
   typedef enum logic {FILLING, ARMED} state_t;

   logic [PAT_W-1:0] hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic [PAT_W-1:0] pat_q,  pat_d;
   logic             y_q,    y_d;

   state_t           state;
   logic [PAT_W-1:0] hist_sh;
   logic [FW-1:0]    fill_inc;

   assign state    = (fill_q == FULL) ? ARMED : FILLING;
   assign hist_sh  = {hist_q[PAT_W-2:0], bus.x};
   assign fill_inc = (state == ARMED) ? FULL : fill_q + FW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         pat_q  <= RST_PAT;
         y_q    <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         pat_q  <= pat_d;
         y_q    <= y_d;
      end
   end

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      pat_d  = pat_q;
      y_d    = 1'b0;

      if (bus.load || bus.clear) begin
         // Either control restarts the fill; the bit on x this edge is dropped.
         fill_d = '0;
         if (bus.load)  pat_d = bus.pattern_in;
         if (bus.clear) begin
            cnt_d  = '0;
            hist_d = '0;
         end
      end else if (bus.en) begin
         hist_d = hist_sh;
         if ((fill_inc == FULL) && (hist_sh == pat_q)) begin
            y_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            // Non-overlapping: the bits of this match may not seed another one.
            fill_d = bus.overlap ? FULL : '0;
         end else begin
            fill_d = fill_inc;
         end
      end
   end

   assign bus.y       = y_q;
   assign bus.count   = cnt_q;
   assign bus.pattern = pat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Two detector instances: A (PAT_W=4, CNT_W=8, RST_PAT=1011) and
// B (PAT_W=8, CNT_W=2, RST_PAT=A5). Every clock step both are compared against
// a behavioural model that tracks the accepted bit stream as an integer and a
// count of bits since the last restart.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

   logic clk;
   logic rst;
   int   nchk  = 0;
   int   nfail = 0;

   seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) ifa ();
   seq_detector_param_if #(.PAT_W(8), .CNT_W(2)) ifb ();

   seq_detector_param #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1011)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   seq_detector_param #(.PAT_W(8), .CNT_W(2), .RST_PAT(8'hA5)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint unsigned recent;  // accepted bits, newest in bit 0
      int unsigned     nv;      // bits accepted since last restart
      int unsigned     cnt;
      int unsigned     pat;
      bit              y;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mreset(input int unsigned rp);
      mdl_t m;
      m.recent = 0;
      m.nv     = 0;
      m.cnt    = 0;
      m.pat    = rp;
      m.y      = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input int pw, input int cw,
                                  input bit x, input bit en, input bit ov,
                                  input bit ld, input bit cl, input int unsigned pin);
      mdl_t n = m;
      longint unsigned mask = (64'd1 << pw) - 64'd1;
      n.y = 1'b0;
      if (ld || cl) begin
         n.nv = 0;
         if (ld) n.pat = pin;
         if (cl) n.cnt = 0;
      end else if (en) begin
         n.recent = ((m.recent << 1) | 64'(x)) & mask;
         n.nv     = m.nv + 1;
         if (n.nv >= pw && n.recent == 64'(n.pat)) begin
            n.y = 1'b1;
            if (n.cnt < (32'd1 << cw) - 1) n.cnt = n.cnt + 1;
            if (!ov) n.nv = 0;
         end
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv_a(input bit x, input bit en, input bit ov, input bit ld,
                        input bit cl, input logic [3:0] pin);
      ifa.x = x; ifa.en = en; ifa.overlap = ov;
      ifa.load = ld; ifa.clear = cl; ifa.pattern_in = pin;
   endtask

   task automatic drv_b(input bit x, input bit en, input bit ov, input bit ld,
                        input bit cl, input logic [7:0] pin);
      ifb.x = x; ifb.en = en; ifb.overlap = ov;
      ifb.load = ld; ifb.clear = cl; ifb.pattern_in = pin;
   endtask

   // One clock edge: advance the models on the inputs presented, then compare.
   task automatic tick();
      ma = mstep(ma, 4, 8, ifa.x, ifa.en, ifa.overlap, ifa.load, ifa.clear, 32'(ifa.pattern_in));
      mb = mstep(mb, 8, 2, ifb.x, ifb.en, ifb.overlap, ifb.load, ifb.clear, 32'(ifb.pattern_in));
      @(posedge clk);
      #1;
      chk("a_y",       32'(ifa.y),       32'(ma.y));
      chk("a_count",   32'(ifa.count),   ma.cnt);
      chk("a_pattern", 32'(ifa.pattern), ma.pat);
      chk("b_y",       32'(ifb.y),       32'(mb.y));
      chk("b_count",   32'(ifb.count),   mb.cnt);
      chk("b_pattern", 32'(ifb.pattern), mb.pat);
   endtask

   // Send n bits of v, MSB first; ym collects y after each bit (first bit oldest).
   task automatic bits_a(input logic [15:0] v, input int n, input bit ov, output logic [15:0] ym);
      ym = '0;
      for (int i = n - 1; i >= 0; i--) begin
         drv_a(v[i], 1'b1, ov, 1'b0, 1'b0, 4'h0);
         tick();
         ym = {ym[14:0], ifa.y};
      end
      drv_a(1'b0, 1'b0, ov, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic bits_b(input logic [15:0] v, input int n, input bit ov, output logic [15:0] ym);
      ym = '0;
      for (int i = n - 1; i >= 0; i--) begin
         drv_b(v[i], 1'b1, ov, 1'b0, 1'b0, 8'h00);
         tick();
         ym = {ym[14:0], ifb.y};
      end
      drv_b(1'b0, 1'b0, ov, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      logic [15:0] ym;
      int          sat_exp [4];
      sat_exp = '{2, 3, 3, 3};

      rst = 1'b0;
      drv_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      drv_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      ma = mreset(32'hB);
      mb = mreset(32'hA5);
      #12;
      chk("rst_a_y",       32'(ifa.y),       32'd0);
      chk("rst_a_count",   32'(ifa.count),   32'd0);
      chk("rst_a_pattern", 32'(ifa.pattern), 32'hB);
      chk("rst_b_pattern", 32'(ifb.pattern), 32'hA5);
      rst = 1'b1;

      // Overlapping: 1011011 -> pulses after bits 4 and 7.
      bits_a(16'b1011011, 7, 1'b1, ym);
      chk("ovl_pulses", 32'(ym), 32'b0001001);
      chk("ovl_count",  32'(ifa.count), 32'd2);

      drv_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      tick();
      chk("clr_count", 32'(ifa.count), 32'd0);

      // Non-overlapping: same stream -> single pulse after bit 4.
      bits_a(16'b1011011, 7, 1'b0, ym);
      chk("novl_pulses", 32'(ym), 32'b0001000);
      chk("novl_count",  32'(ifa.count), 32'd1);

      // Gap of three en=0 cycles between bits 2 and 3.
      drv_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      tick();
      drv_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0); tick();
      drv_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0); tick();
      for (int i = 0; i < 3; i++) begin
         drv_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
         tick();
      end
      drv_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0); tick();
      chk("gap_y3", 32'(ifa.y), 32'd0);
      drv_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0); tick();
      chk("gap_y4",    32'(ifa.y),     32'd1);
      chk("gap_count", 32'(ifa.count), 32'd1);

      // Load 0110 while x=1/en=1 (bit must be dropped), then stream 0110.
      drv_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110);
      tick();
      chk("load_pattern", 32'(ifa.pattern), 32'h6);
      chk("load_count",   32'(ifa.count),   32'd1);
      bits_a(16'b0110, 4, 1'b0, ym);
      chk("load_pulses", 32'(ym), 32'b0001);
      chk("load_count2", 32'(ifa.count), 32'd2);

      // Asynchronous reset mid-stream; checked between clock edges.
      bits_a(16'b101, 3, 1'b1, ym);
      rst = 1'b0;
      #2;
      chk("arst_a_y",       32'(ifa.y),       32'd0);
      chk("arst_a_count",   32'(ifa.count),   32'd0);
      chk("arst_a_pattern", 32'(ifa.pattern), 32'hB);
      chk("arst_b_pattern", 32'(ifb.pattern), 32'hA5);
      ma = mreset(32'hB);
      mb = mreset(32'hA5);
      #28;
      rst = 1'b1;
      bits_a(16'b1, 1, 1'b1, ym);
      chk("arst_fresh", 32'(ym), 32'd0);
      bits_a(16'b1011, 4, 1'b1, ym);
      chk("arst_pulses", 32'(ym), 32'b0001);

      // Width: 8-bit pattern A5.
      bits_b(16'h00A5, 8, 1'b0, ym);
      chk("w8_pulses", 32'(ym), 32'h0001);
      chk("w8_count",  32'(ifb.count), 32'd1);
      bits_b(16'b1010010, 7, 1'b0, ym);
      chk("w8_short", 32'(ym), 32'd0);

      // Saturation at 3 with CNT_W=2.
      drv_b(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
      tick();
      chk("sat_clr", 32'(ifb.count), 32'd0);
      bits_b(16'h00FF, 8, 1'b1, ym);
      chk("sat_c1", 32'(ifb.count), 32'd1);
      for (int i = 0; i < 4; i++) begin
         bits_b(16'h0001, 1, 1'b1, ym);
         chk("sat_cn", 32'(ifb.count), 32'(sat_exp[i]));
      end
      drv_b(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      tick();
      chk("sat_clr_count", 32'(ifb.count), 32'd0);
      chk("sat_clr_y",     32'(ifb.y),     32'd0);
      bits_b(16'h007F, 7, 1'b1, ym);
      chk("sat_fresh7", 32'(ym), 32'd0);
      bits_b(16'h0001, 1, 1'b1, ym);
      chk("sat_fresh8", 32'(ym), 32'd1);

      // Randomized traffic on both instances.
      for (int i = 0; i < 600; i++) begin
         drv_a(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 31) == 0), ($urandom_range(0, 47) == 0),
               4'($urandom_range(0, 15)));
         drv_b(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 63) == 0),
               (($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(0, 255))));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, the successor to the fixed single-pattern FSM. It samples a 1-bit serial stream and compares the most recent PAT_W accepted bits against a run-time loadable pattern. Overlapping or non-overlapping matching is selectable, and a saturating match counter is provided. It sits between a serial input source and downstream control or status logic, in the same one-bit-in / one-flag-out position as the earlier detector.

## Interface
- PAT_W, 4: pattern length in bits, 2..16.
- CNT_W, 8: match counter width, ≥1.
- RST_PAT, 4'b1011: pattern register value after reset, PAT_W bits.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-low reset. Asserted (0) forces all state to reset values immediately; deassertion takes effect at the next clk edge.
- x  input  1  serial data bit.
- en  input  1  bit valid; x is accepted only on edges where en=1.
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled every edge.
- load  input  1  synchronous pulse; latches pattern_in into the pattern register.
- pattern_in  input  PAT_W  new pattern; bit PAT_W-1 is the first (oldest) bit of the sequence.
- clear  input  1  synchronous pulse; clears the counter and history.
- y  output  1  registered match flag.
- count  output  CNT_W  saturating number of matches since reset or clear.
- pattern  output  PAT_W  current pattern register contents.

## Operation
- Internal state:
  - hist[PAT_W-1:0]: shift register; a new bit enters at bit 0, and the oldest bit sits at bit PAT_W-1.
  - fill: 0..PAT_W, saturating, counts valid bits held in hist.
  - pat: the pattern register.
- States: FILLING (fill<PAT_W) and ARMED (fill==PAT_W). The state is a function of fill.
- Accepted bit, on an edge with en=1 and neither load nor clear:
  - hist_next = {hist[PAT_W-2:0], x}.
  - fill_next = min(fill+1, PAT_W).
- Match condition: fill_next==PAT_W and hist_next==pat.
- On a match:
  - y←1.
  - count←count+1, saturating at 2^CNT_W−1; it never wraps.
  - If overlap=0, fill←0 (FILLING), so the bits just used cannot start another match.
  - If overlap=1, fill stays at PAT_W.
- No match, or en=0: y←0. With en=0, hist, fill and count are held.
- load=1:
  - pat←pattern_in; fill←0; y←0.
  - count is unchanged; the bit on x that edge is discarded.
- clear=1: count←0; fill←0; y←0; the bit on x that edge is discarded.
- load and clear in the same edge: both effects apply.
- Priority: rst > (load/clear) > en.
- Reset values: y=0, count=0, pattern=RST_PAT, hist=0, fill=0.

## Timing
- y is registered and rises on the clk edge that samples the final pattern bit. It is visible one cycle after that bit's setup and stays high exactly one cycle per match.
- count updates on the same edge as y.
- Back-to-back matches with overlap=1, where the pattern is self-overlapping, give consecutive y pulses. For example, pattern 1111 with a stream of all ones gives y=1 every accepted bit after the 4th.
- overlap is evaluated on the matching edge. Toggling it mid-stream affects only subsequent matches.
- pattern_in is loaded on the load edge. The new pattern is used for bits accepted from the next edge onward, so the first possible match is PAT_W accepted bits after load.
- Reset asserted mid-operation:
  - y, count and fill go to 0 asynchronously, without waiting for clk.
  - The pattern returns to RST_PAT.
  - The first bit accepted after release starts a fresh fill.

## Test plan
- Reset: rst=0 for 30 ns mid-stream → y=0, count=0 and pattern=4'b1011 immediately; no y pulse until 4 bits are accepted after release.
- Overlapping matches: overlap=1, pattern 1011, stream 1011011 (en=1) → y pulses after bits 4 and 7; count=2.
- Non-overlapping matches: overlap=0, same stream → y pulses after bit 4 only; count=1.
- Gaps and load: stream 1011 with en=0 inserted for 3 cycles between bits 2 and 3 → single y pulse after the 4th accepted bit. Then load pattern_in=0110 with stream 0110 → y after the 4th bit following load; count=2.
- Saturation and clear: CNT_W=2, pattern 1111, overlap=1, 8 ones → count sequence 1,2,3,3,3; then clear=1 → count=0, y=0, and the next match needs 4 fresh bits.
- Width parameter: PAT_W=8, RST_PAT=8'hA5, stream 10100101 → y after the 8th bit; 7 bits only → no pulse.
